// File: rtl/pong_pkg.sv
// Shared pong definitions: field geometry, direction/score codes and the
// ball sequencing state type used by the ball and paddle datapaths.
package pong_pkg;

   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int BALL_SIZE = 8;

   localparam logic [1:0] DIR_RIGHT  = 2'b10;
   localparam logic [1:0] DIR_LEFT   = 2'b01;
   localparam logic [1:0] PONTO_MISS = 2'b01;
   localparam logic [1:0] PONTO_PLAY = 2'b10;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      MOVE  = 2'd1,
      MISS  = 2'd2
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// Motion step generator: a free-running divider that emits a one-cycle
// pulse every TICK_DIV clocks, restarting its count on reset.
module tick_gen #(
   parameter int TICK_DIV = 250000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Divider count, wrapping at TICK_DIV-1; the pulse marks the wrap cycle.
   always_ff @(posedge clock) begin
      if (!reset)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/ball_motion.sv
// Ball kinematics: registered ball edges, one-pixel horizontal steps,
// paddle-sector vertical speed with wall bounce, and serve/miss sequencing.
module ball_motion #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int BALL_SIZE   = 8,
   parameter int X_START     = 316,
   parameter int Y_START     = 236,
   parameter int TICK_DIV    = 250000,
   parameter int SERVE_TICKS = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] sentido_x,
   input  logic [1:0] ponto,
   input  logic       setor1,
   input  logic       setor2,
   input  logic       setor3,
   input  logic       setor4,
   input  logic       setor5,
   input  logic       setor6,
   output logic [9:0] Pos_bola_I_x,
   output logic [9:0] Pos_bola_F_x,
   output logic [9:0] Pos_bola_S_y,
   output logic [9:0] Pos_bola_I_y,
   output logic       ball_live
);

   import pong_pkg::*;

   localparam int                SC_W    = $clog2(SERVE_TICKS + 1);
   localparam logic [SC_W-1:0]   SC_LAST = SC_W'(SERVE_TICKS - 1);
   localparam logic [9:0]        EDGE    = 10'(BALL_SIZE - 1);
   localparam logic [9:0]        X_RST   = 10'(X_START);
   localparam logic [9:0]        Y_RST   = 10'(Y_START);
   localparam logic [9:0]        Y_FLOOR = 10'(V_RES - BALL_SIZE);
   localparam logic [10:0]       X_WALL  = 11'(H_RES - 1);
   localparam logic [10:0]       Y_WALL  = 11'(V_RES - 1);

   state_t          r_state;
   logic [9:0]      r_ix, r_fx, r_sy, r_iy;
   logic [1:0]      r_vy;
   logic            r_vup;
   logic [SC_W-1:0] r_sc;
   logic            r_live;

   logic            w_tick;
   logic [1:0]      w_vy;
   logic            w_vup;
   logic [9:0]      w_ix_nx;
   logic [9:0]      w_sy_nx;
   logic            w_vup_nx;
   logic [10:0]     w_vy11;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (w_tick)
   );

   // Paddle-sector priority encoder: the topmost asserted sector sets speed/direction.
   always_comb begin
      w_vy  = r_vy;
      w_vup = r_vup;
      if (setor1)      begin w_vy = 2'd3; w_vup = 1'b1; end
      else if (setor2) begin w_vy = 2'd2; w_vup = 1'b1; end
      else if (setor3) begin w_vy = 2'd1; w_vup = 1'b1; end
      else if (setor4) begin w_vy = 2'd1; w_vup = 1'b0; end
      else if (setor5) begin w_vy = 2'd2; w_vup = 1'b0; end
      else if (setor6) begin w_vy = 2'd3; w_vup = 1'b0; end
   end

   // Candidate position for a tick in MOVE; wall checks use 11-bit sums so they never wrap.
   always_comb begin
      w_vy11   = {9'd0, w_vy};
      w_ix_nx  = r_ix;
      w_sy_nx  = r_sy;
      w_vup_nx = w_vup;
      if (sentido_x == DIR_RIGHT && {1'b0, r_fx} < X_WALL)
         w_ix_nx = r_ix + 10'd1;
      else if (sentido_x == DIR_LEFT && r_ix != 10'd0)
         w_ix_nx = r_ix - 10'd1;
      if (w_vy != 2'd0) begin
         if (w_vup) begin
            if ({1'b0, r_sy} <= w_vy11) begin
               w_sy_nx  = 10'd0;
               w_vup_nx = 1'b0;
            end else begin
               w_sy_nx = r_sy - {8'd0, w_vy};
            end
         end else begin
            if ({1'b0, r_iy} + w_vy11 >= Y_WALL) begin
               w_sy_nx  = Y_FLOOR;
               w_vup_nx = 1'b1;
            end else begin
               w_sy_nx = r_sy + {8'd0, w_vy};
            end
         end
      end
   end

   // Serve/move/miss sequencer with all ball edges registered together.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= SERVE;
         r_ix    <= X_RST;
         r_fx    <= X_RST + EDGE;
         r_sy    <= Y_RST;
         r_iy    <= Y_RST + EDGE;
         r_vy    <= 2'd0;
         r_vup   <= 1'b0;
         r_sc    <= '0;
         r_live  <= 1'b0;
      end else begin
         case (r_state)
            SERVE: begin
               if (w_tick) begin
                  if (r_sc == SC_LAST) begin
                     r_state <= MOVE;
                     r_sc    <= '0;
                     r_live  <= 1'b1;
                  end else begin
                     r_sc <= r_sc + SC_W'(1);
                  end
               end
            end
            MOVE: begin
               if (ponto == PONTO_MISS) begin
                  r_state <= MISS;
                  r_sc    <= '0;
                  r_live  <= 1'b0;
               end else begin
                  r_vy  <= w_vy;
                  r_vup <= w_vup;
                  if (w_tick) begin
                     r_ix  <= w_ix_nx;
                     r_fx  <= w_ix_nx + EDGE;
                     r_sy  <= w_sy_nx;
                     r_iy  <= w_sy_nx + EDGE;
                     r_vup <= w_vup_nx;
                  end
               end
            end
            MISS: begin
               if (w_tick) begin
                  if (r_sc == SC_LAST) begin
                     r_state <= SERVE;
                     r_sc    <= '0;
                     r_ix    <= X_RST;
                     r_fx    <= X_RST + EDGE;
                     r_sy    <= Y_RST;
                     r_iy    <= Y_RST + EDGE;
                     r_vy    <= 2'd0;
                     r_vup   <= 1'b0;
                  end else begin
                     r_sc <= r_sc + SC_W'(1);
                  end
               end
            end
            default: begin
               r_state <= SERVE;
               r_sc    <= '0;
               r_live  <= 1'b0;
            end
         endcase
      end
   end

   assign Pos_bola_I_x = r_ix;
   assign Pos_bola_F_x = r_fx;
   assign Pos_bola_S_y = r_sy;
   assign Pos_bola_I_y = r_iy;
   assign ball_live    = r_live;

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball kinematics engine for the pong datapath; it is the writer of the ball-position bus that the collision/impact logic reads. It converts the impact logic's direction, score and paddle-sector outputs into registered ball coordinates: one pixel per step horizontally, sector-dependent vertical speed, top/bottom wall bounce, and miss/serve sequencing.

## Interface
Parameters:
- H_RES, 640: field width in pixels.
- V_RES, 480: field height in pixels.
- BALL_SIZE, 8: ball edge length in pixels.
- X_START, 316: serve left edge (x).
- Y_START, 236: serve top edge (y).
- TICK_DIV, 250000: clock cycles per motion step.
- SERVE_TICKS, 60: steps held in SERVE and MISS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- sentido_x  in  2  horizontal direction: 2'b10 right, 2'b01 left, others hold x.
- ponto  in  2  2'b01 miss (point lost), 2'b10 in play, others ignored.
- setor1..setor6  in  1 each  paddle-sector hit flags, sector 1 = paddle top.
- Pos_bola_I_x  out  10  ball left edge.
- Pos_bola_F_x  out  10  ball right edge = I_x + BALL_SIZE − 1.
- Pos_bola_S_y  out  10  ball top edge.
- Pos_bola_I_y  out  10  ball bottom edge = S_y + BALL_SIZE − 1.
- ball_live  out  1  high only in MOVE.

## Operation
- Reset (reset == 0 at a clock edge): state SERVE, I_x = X_START, F_x = X_START+BALL_SIZE−1, S_y = Y_START, I_y = Y_START+BALL_SIZE−1, vy = 0, vdir = down, tick counter 0, serve counter 0, ball_live 0.
- Step tick: 1-cycle pulse every TICK_DIV cycles; counter free-running from reset.
- States:
  - SERVE: ball at start position, vy = 0. Count SERVE_TICKS ticks, then → MOVE.
  - MOVE: on each tick, apply x then y update; ponto == 2'b01 sampled on any cycle → MISS (takes priority over that cycle's tick update).
  - MISS: position frozen; count SERVE_TICKS ticks, then → SERVE with position recentered and vy = 0 in the same edge.
- ponto and setor are ignored outside MOVE.
- x update (MOVE, tick): sentido_x 2'b10 → I_x+1, saturating at F_x = H_RES−1; 2'b01 → I_x−1, saturating at I_x = 0; else hold. Single-pixel step is mandatory: the impact logic compares on exact x values.
- Sector latch (MOVE, any cycle): lowest-index asserted setor wins. 1: up, 3. 2: up, 2. 3: up, 1. 4: down, 1. 5: down, 2. 6: down, 3. None asserted: keep vy/vdir. A latch and a tick in the same cycle: the tick uses the new velocity.
- y update (MOVE, tick): up → if S_y ≤ vy then S_y = 0 and vdir = down, else S_y − vy. Down → if I_y + vy ≥ V_RES−1 then I_y = V_RES−1 and vdir = up, else S_y + vy. vy = 0 → hold.
- Derived edges (F_x, I_y) are registered together with I_x and S_y; never inconsistent on any cycle.
- Arithmetic: 10-bit unsigned; wall compares use 11-bit intermediates so they cannot wrap.

## Timing
- Positions change only on the clock edge following the tick-qualified cycle; latency from tick to new position is 1 cycle.
- MISS entry: 1 cycle after ponto == 2'b01 is seen; ball_live drops the same edge.
- SERVE → MOVE: on the edge of the SERVE_TICKS-th tick; first motion happens on the next tick.
- Reset mid-operation: the next edge restores the full reset state, with counters cleared regardless of state.
- Simultaneous wall bounce and sector latch: the latch sets vdir first and the wall check uses it.

## Structure
- Shared package pong_pkg: H_RES, V_RES, BALL_SIZE, DIR_RIGHT = 2'b10, DIR_LEFT = 2'b01, PONTO_MISS = 2'b01, PONTO_PLAY = 2'b10, state enum {SERVE, MOVE, MISS}.
- Sub-module tick_gen (parameter TICK_DIV; ports clock, reset, tick). It is reused by the paddle controllers.
- Sector-to-velocity priority encoder inline in ball_motion.

## Test plan
Use TICK_DIV = 4 and SERVE_TICKS = 2 in the bench.
- Reset, then release: outputs are 316/323/236/243 and ball_live = 0. After 2 ticks ball_live = 1.
- MOVE, sentido_x = 2'b01, no setor: I_x drops by 1 per tick (316 → 315 → 314). S_y stays 236.
- Pulse setor1 for 1 cycle with S_y = 5: next tick S_y = 2. The following tick clamps S_y to 0 and sets vdir down. The tick after that gives S_y = 3.
- setor6 then setor2 in the same cycle: setor2 wins, vy = 2 up.
- sentido_x = 2'b10 with I_x = 632: F_x reaches 639 and saturates.
- ponto = 2'b01 with I_x = 8: ball freezes and ball_live = 0. After 2 ticks the ball is recentered to 316/236 in SERVE with vy = 0. Assert reset mid-MISS: state returns to SERVE within 1 cycle.
